// File: rtl/health_pkg.sv
// Shared definitions for the health-monitor resource sequencers: FSM states,
// detector abnormality codes and a severity-max helper.
package health_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_e;

  localparam logic [1:0] ABN_NONE = 2'b00;
  localparam logic [1:0] ABN_LOW  = 2'b01;
  localparam logic [1:0] ABN_MID  = 2'b10;
  localparam logic [1:0] ABN_HIGH = 2'b11;

  // Codes are ordered by severity, so the worst one is the unsigned maximum.
  function automatic logic [1:0] abn_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after
// ptr_i (with wrap) and returns it as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] k_s;
  logic             hit_s;
  logic             found_s;

  // Walk the channels starting just after the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    k_s     = '0;
    hit_s   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      sum_s   = {1'b0, ptr_i} + (IDX_W+1)'(i);
      k_s     = (sum_s >= (IDX_W+1)'(N)) ? IDX_W'(sum_s - (IDX_W+1)'(N)) : IDX_W'(sum_s);
      hit_s   = req_i[k_s] & ~found_s;
      grant_o[k_s] = grant_o[k_s] | hit_s;
      idx_o   = hit_s ? k_s : idx_o;
      found_s = found_s | hit_s;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/vital_scan_sequencer.sv
// Time-shares one serial abnormality detector among N_CH patient channels:
// arbitrate, flush detector history, shift a frame MSB-first, report worst code.
module vital_scan_sequencer
  import health_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int FRAME_W   = 8,
  parameter int FLUSH_LEN = 4,
  parameter int DET_LAT   = 2,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*FRAME_W-1:0] frame_data,
  output logic [N_CH-1:0]         grant,
  output logic                    det_data,
  input  logic [1:0]              det_abn,
  output logic                    res_valid,
  output logic [CH_W-1:0]         res_ch,
  output logic [1:0]              res_code,
  output logic [N_CH-1:0]         alarm,
  input  logic [N_CH-1:0]         alarm_clr,
  output logic                    busy
);

  localparam int CNT_MAX0 = (FLUSH_LEN > FRAME_W) ? FLUSH_LEN : FRAME_W;
  localparam int CNT_MAX  = (CNT_MAX0 > DET_LAT) ? CNT_MAX0 : DET_LAT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FRAME_W-1:0]  shreg_q;
  logic [CH_W-1:0]     ch_q;
  logic [CH_W-1:0]     ptr_q;
  logic [1:0]          worst_q;
  logic [N_CH-1:0]     grant_q;
  logic                det_data_q;
  logic                res_valid_q;
  logic [CH_W-1:0]     res_ch_q;
  logic [1:0]          res_code_q;
  logic                busy_q;
  logic [N_CH-1:0]     alarm_q;
  logic [N_CH-1:0]     alarm_d;
  logic [N_CH-1:0]     alarm_set_s;
  logic [N_CH-1:0]     arb_grant_s;
  logic [CH_W-1:0]     arb_idx_s;
  logic                arb_valid_s;
  logic [FRAME_W-1:0]  frame_sel_s;
  logic [1:0]          worst_next_s;

  rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  // Mux the winning channel's frame out of the flattened bus.
  always_comb begin
    frame_sel_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      frame_sel_s = frame_sel_s | (frame_data[k*FRAME_W +: FRAME_W] & {FRAME_W{arb_grant_s[k]}});
    end
  end

  assign worst_next_s = abn_max(worst_q, det_abn);

  // Sequencer FSM; every output is registered for the cycle it belongs to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ch_q        <= '0;
      ptr_q       <= CH_W'(N_CH - 1);
      worst_q     <= ABN_NONE;
      grant_q     <= '0;
      det_data_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_code_q  <= ABN_NONE;
      busy_q      <= 1'b0;
    end else begin
      grant_q     <= '0;
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          det_data_q <= 1'b0;
          if (arb_valid_s) begin
            grant_q <= arb_grant_s;
            ch_q    <= arb_idx_s;
            ptr_q   <= arb_idx_s;
            worst_q <= ABN_NONE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (FLUSH_LEN == 0) begin
              state_q    <= SHIFT;
              det_data_q <= frame_sel_s[FRAME_W-1];
              shreg_q    <= frame_sel_s << 1;
            end else begin
              state_q <= FLUSH;
              shreg_q <= frame_sel_s;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        FLUSH: begin
          if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
            state_q    <= SHIFT;
            det_data_q <= shreg_q[FRAME_W-1];
            shreg_q    <= shreg_q << 1;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          worst_q <= worst_next_s;
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_q    <= DRAIN;
            det_data_q <= 1'b0;
            cnt_q      <= '0;
          end else begin
            det_data_q <= shreg_q[FRAME_W-1];
            shreg_q    <= shreg_q << 1;
            cnt_q      <= cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          worst_q <= worst_next_s;
          if (cnt_q == CNT_W'(DET_LAT - 1)) begin
            state_q     <= REPORT;
            res_valid_q <= 1'b1;
            res_code_q  <= worst_next_s;
            res_ch_q    <= ch_q;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        REPORT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          det_data_q <= 1'b0;
          cnt_q      <= '0;
        end
      endcase
    end
  end

  // A report setting an alarm beats a simultaneous clear on the same channel.
  always_comb begin
    alarm_set_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      alarm_set_s[k] = res_valid_q & (res_code_q != ABN_NONE) & (res_ch_q == CH_W'(k));
    end
    alarm_d = (alarm_q & ~alarm_clr) | alarm_set_s;
  end

  // Sticky alarm bank.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q <= '0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign grant     = grant_q;
  assign det_data  = det_data_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_code  = res_code_q;
  assign alarm     = alarm_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vital_scan_sequencer.sv
// Bench for vital_scan_sequencer: directed and randomized frames checked against
// a frame-level model (bit sequence, window max, round-robin order, alarms).
module tb_vital_scan_sequencer;

  localparam int N  = 4;
  localparam int FW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_a, req_b, alarm_clr;
  logic [N*FW-1:0] frame_data;
  logic [1:0]    det_abn;

  logic [N-1:0]  grant_a, grant_b, alarm_a, alarm_b;
  logic          det_a, det_b, rv_a, rv_b, busy_a, busy_b;
  logic [1:0]    rch_a, rch_b, rcode_a, rcode_b;

  always #5 clock = ~clock;

  vital_scan_sequencer dut_a (
    .clock(clock), .reset_n(reset_n), .req(req_a), .frame_data(frame_data),
    .grant(grant_a), .det_data(det_a), .det_abn(det_abn), .res_valid(rv_a),
    .res_ch(rch_a), .res_code(rcode_a), .alarm(alarm_a), .alarm_clr(alarm_clr),
    .busy(busy_a)
  );

  vital_scan_sequencer #(.FLUSH_LEN(0), .DET_LAT(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .req(req_b), .frame_data(frame_data),
    .grant(grant_b), .det_data(det_b), .det_abn(det_abn), .res_valid(rv_b),
    .res_ch(rch_b), .res_code(rcode_b), .alarm(alarm_b), .alarm_clr(alarm_clr),
    .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int prev_grant_cyc = 0;
  int last_ch;
  logic [N-1:0] alarm_m;
  logic [1:0]   abn_seq [0:31];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (last + i) % N;
      if (r[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic clear_abn();
    for (int i = 0; i < 32; i++) abn_seq[i] = 2'b00;
  endtask

  task automatic alarm_pulse(input logic [N-1:0] v);
    alarm_clr = v;
    @(negedge clock);
    alarm_clr = '0;
    alarm_m   = alarm_m & ~v;
    chk("alarm_after_clr", alarm_a, alarm_m);
  endtask

  // Follows one frame from its grant to the IDLE cycle after REPORT.
  task automatic do_frame(input bit b, input int exp_ch, input bit hold,
                          input bit chk_period, input logic [N-1:0] clr_rep);
    int fl, dl, len, t;
    logic [FW-1:0] fr;
    logic [1:0] worst;
    logic [N-1:0] eg, og;
    logic eb;
    fl  = b ? 0 : 4;
    dl  = b ? 1 : 2;
    len = fl + FW + dl;
    t   = 0;
    og  = b ? grant_b : grant_a;
    while (og == '0 && t < 60) begin
      @(negedge clock);
      t++;
      og = b ? grant_b : grant_a;
    end
    eg = '0;
    eg[exp_ch] = 1'b1;
    chk("grant", og, eg);
    if (chk_period) chk("grant_period", cyc - prev_grant_cyc, 2 + fl + FW + dl);
    prev_grant_cyc = cyc;
    fr = frame_data[exp_ch*FW +: FW];
    worst = 2'b00;
    for (int c = fl; c < len; c++) worst = (abn_seq[c] > worst) ? abn_seq[c] : worst;
    for (int c = 0; c <= len; c++) begin
      eb = (c >= fl && c < fl + FW) ? fr[FW-1-(c-fl)] : 1'b0;
      if (c < len) chk($sformatf("det_data_c%0d", c), b ? det_b : det_a, eb);
      if (c > 0) chk($sformatf("grant_low_c%0d", c), b ? grant_b : grant_a, 0);
      chk($sformatf("busy_c%0d", c), b ? busy_b : busy_a, 1);
      chk($sformatf("res_valid_c%0d", c), b ? rv_b : rv_a, (c == len) ? 1 : 0);
      if (c == len) begin
        chk("res_ch", b ? rch_b : rch_a, exp_ch);
        chk("res_code", b ? rcode_b : rcode_a, worst);
        alarm_clr = clr_rep;
      end
      if (c == 3 && !hold) begin
        frame_data = {$urandom, $urandom};
        if (b) req_b = 4'($urandom); else req_a = 4'($urandom);
      end
      if (c == len - 1 && !hold) begin
        if (b) req_b = '0; else req_a = '0;
      end
      det_abn = (c < len) ? abn_seq[c] : 2'b00;
      @(negedge clock);
    end
    alarm_clr = '0;
    det_abn   = 2'b00;
    if (!b) begin
      alarm_m = alarm_m & ~clr_rep;
      if (worst != 2'b00) alarm_m[exp_ch] = 1'b1;
      chk("alarm", alarm_a, alarm_m);
      last_ch = exp_ch;
    end
    chk("res_valid_after", b ? rv_b : rv_a, 0);
    chk("busy_after", b ? busy_b : busy_a, 0);
    chk("res_ch_hold", b ? rch_b : rch_a, exp_ch);
  endtask

  initial begin
    int exp, t;
    logic [N-1:0] r;
    reset_n = 1'b0; req_a = '0; req_b = '0; alarm_clr = '0;
    frame_data = '0; det_abn = 2'b00;
    last_ch = N - 1; alarm_m = '0;
    clear_abn();
    repeat (3) @(negedge clock);
    chk("rst_grant", grant_a, 0);
    chk("rst_det", det_a, 0);
    chk("rst_valid", rv_a, 0);
    chk("rst_ch", rch_a, 0);
    chk("rst_code", rcode_a, 0);
    chk("rst_alarm", alarm_a, 0);
    chk("rst_busy", busy_a, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_det", det_a, 0);

    // Round robin with every channel requesting continuously.
    frame_data = {$urandom, $urandom};
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp = rr_pick(4'b1111, last_ch);
      do_frame(1'b0, exp, (i < 4), (i > 0), '0);
    end
    @(negedge clock);

    // Directed frame 0xA5 on channel 2, detector quiet.
    frame_data = {$urandom, $urandom};
    frame_data[2*FW +: FW] = 8'hA5;
    req_a = 4'b0100;
    clear_abn();
    do_frame(1'b0, rr_pick(4'b0100, last_ch), 1'b0, 1'b0, '0);

    // Same frame; FLUSH-time code ignored, DRAIN-time code counted.
    frame_data[2*FW +: FW] = 8'hA5;
    req_a = 4'b0100;
    abn_seq[2] = 2'b11; abn_seq[9] = 2'b01; abn_seq[13] = 2'b01;
    do_frame(1'b0, rr_pick(4'b0100, last_ch), 1'b0, 1'b0, '0);
    alarm_pulse(4'b0100);

    // Alarm set on ch1, then set-vs-clear collision, then plain clear.
    clear_abn();
    abn_seq[5] = 2'b10;
    frame_data = {$urandom, $urandom};
    req_a = 4'b0010;
    do_frame(1'b0, rr_pick(4'b0010, last_ch), 1'b0, 1'b0, '0);
    clear_abn();
    abn_seq[6] = 2'b10;
    frame_data = {$urandom, $urandom};
    req_a = 4'b0010;
    do_frame(1'b0, rr_pick(4'b0010, last_ch), 1'b0, 1'b0, 4'b0010);
    @(negedge clock);
    alarm_pulse(4'b0010);

    // Randomized requests, frames and detector codes.
    for (int n = 0; n < 10; n++) begin
      r = 4'($urandom_range(1, 15));
      frame_data = {$urandom, $urandom};
      for (int i = 0; i < 32; i++) abn_seq[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      req_a = r;
      do_frame(1'b0, rr_pick(r, last_ch), 1'b0, 1'b0, '0);
    end

    // Reset in the middle of SHIFT.
    clear_abn();
    abn_seq[4] = 2'b11;
    frame_data = {$urandom, $urandom};
    req_a = 4'b0100;
    t = 0;
    while (grant_a == '0 && t < 60) begin @(negedge clock); t++; end
    chk("pre_reset_grant", grant_a, 4'b0100);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant_a, 0);
    chk("mid_rst_det", det_a, 0);
    chk("mid_rst_valid", rv_a, 0);
    chk("mid_rst_ch", rch_a, 0);
    chk("mid_rst_code", rcode_a, 0);
    chk("mid_rst_alarm", alarm_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    last_ch = N - 1; alarm_m = '0;
    req_a = 4'b0001;
    frame_data = {$urandom, $urandom};
    clear_abn();
    @(negedge clock);
    reset_n = 1'b1;
    do_frame(1'b0, rr_pick(4'b0001, last_ch), 1'b0, 1'b0, '0);

    // No-flush, single-cycle-drain instance.
    frame_data = {$urandom, $urandom};
    for (int i = 0; i < 32; i++) abn_seq[i] = 2'($urandom_range(0, 3));
    req_b = 4'b0001;
    do_frame(1'b1, 0, 1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
